logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, registered logic unit; next generation of the team's 8-bit combinational logic block.
- Configurable WIDTH and 4-bit opcode (8 base ops + 4 optional shift/rotate ops).
- Feedback (chain) operand taken from the last result.
- Zero/parity/error flags.
- One-deep output register with valid/ready handshake, so it can sit directly in the Mini-CPU execute stage or be stalled by a downstream writeback.

Parameters:
- WIDTH, 8, operand/result width in bits; legal values are 2 or more.
- RESET_ACC, 0, value loaded into the chain (feedback) register on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- op_A  in  WIDTH  operand A.
- op_B  in  WIDTH  operand B; ignored when chain=1.
- op_sel  in  4  opcode (see Behaviour).
- chain  in  1  1: operand B = chain register instead of op_B.
- out_valid  out  1  Func/flags valid.
- out_ready  in  1  downstream accepts the result.
- Func  out  WIDTH  result.
- flag_zero  out  1  Func == 0.
- flag_par  out  1  XOR-reduction of Func (odd parity).
- flag_err  out  1  opcode illegal in this build.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- Reset values: out_valid=0, Func=0, flag_zero=0, flag_par=0, flag_err=0, chain register=RESET_ACC.
  - in_ready is combinational; it is 1 in the cycle after reset.
  - rst wins over any simultaneous accept. An in-flight result is discarded and is never presented.
- Handshake:
  - accept = in_valid && in_ready, where in_ready = !out_valid || out_ready.
  - present = out_valid && out_ready.
- Latency: 1 cycle. A request accepted on edge N shows out_valid=1 with its result after edge N.
- Throughput: 1 result/cycle while out_ready=1.
- Stall: when out_valid && !out_ready:
  - Func and all flags are held stable.
  - in_ready=0; no new request is accepted.
- Simultaneous present and accept in the same cycle: the output register is overwritten with the new result and out_valid stays 1 (no bubble).
- Present without accept: out_valid falls to 0 on the next edge. Func and flags keep their last value while invalid.
- Chain register:
  - Updated with the computed result on every accept, whether or not chain=1.
  - With chain=1, B = chain register value as it stood before this accept. This allows back-to-back dependent ops with no bubble.
- Opcodes (B = chain ? chain register : op_B):
  - 0 ior: A|B
  - 1 and: A&B
  - 2 xor: A^B
  - 3 comp: ~A
  - 4 nor: ~(A|B)
  - 5 nand: ~(A&B)
  - 6 xnor: ~(A^B)
  - 7 passB: B
  - 8–11: shift group (see Optional Feature).
  - 12–15: always illegal.
- Illegal opcode handling:
  - Result = 0, flag_err=1, flag_zero=1, flag_par=0.
  - Still consumes a slot and still updates the chain register (to 0).
- Flags are computed from the registered result and are registered with it. No combinational path from op_A/op_B to outputs.
- in_valid=0: no state change except the out_valid drop described above.

Optional Feature:
- Macro: LOGIC_SHIFT_EN.
- Defined, opcodes 8–11 are legal. Shift/rotate is by one position, on A only:
  - 8 shl: {A[W-2:0],0}
  - 9 shr: {0,A[W-1:1]}
  - 10 rol: {A[W-2:0],A[W-1]}
  - 11 ror: {A[0],A[W-1:1]}
- Not defined: opcodes 8–11 are treated as illegal (result 0, flag_err=1). No shifter hardware is synthesised.

Decomposition:
- Package logic_pkg:
  - localparam opcode constants OP_IOR..OP_ROR (4-bit).
  - OP_W=4.
  - function is_legal_op(op), honouring LOGIC_SHIFT_EN.
- Sub-module logic_core:
  - Purely combinational, parametrised WIDTH.
  - Inputs: a, b, op.
  - Outputs: res, err.
  - Generalised successor of the 8-bit combinational unit.
- logic_unit_pipe holds: handshake, output register, chain register, flag registers.

Test Plan:
- WIDTH=8, reset, then op_A=0xC3, op_B=0x5A, op=0,1,2,3 back-to-back with out_ready=1 -> Func=0xDB, 0x42, 0x99, 0x3C on consecutive cycles; flag_par=0,0,0,0; in_ready stays 1.
- Stall: op=4, A=0xF0, B=0x0F accepted, out_ready=0 for 3 cycles while in_valid=1 with op=1 -> Func=0x00, flag_zero=1 held; in_ready=0; second op accepted the cycle out_ready rises; Func then 0x00 (and).
- Chain: accept passB with op_B=0x81, then chain=1, op=2 (xor), A=0xFF -> second Func=0x7E; flag_par=0.
- Illegal op 13, A=0xAA -> Func=0, flag_err=1, flag_zero=1. A following chain=1 passB -> Func=0.
- Shift (LOGIC_SHIFT_EN on, WIDTH=8), A=0x81, ops 8,9,10,11 -> 0x02, 0x40, 0x03, 0xC0. With the macro off -> all four Func=0, flag_err=1.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst one cycle -> out_valid=0, Func=0, chain register=RESET_ACC. The next chain=1 passB returns RESET_ACC.

Source files
------------

// File: rtl/logic_pkg.sv
// Opcode constants and the legality check shared by the logic unit and its core.
// Build option: define LOGIC_SHIFT_EN to make the shift/rotate opcodes 8-11 legal.
package logic_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_IOR   = 4'd0;
    localparam logic [OP_W-1:0] OP_AND   = 4'd1;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd2;
    localparam logic [OP_W-1:0] OP_COMP  = 4'd3;
    localparam logic [OP_W-1:0] OP_NOR   = 4'd4;
    localparam logic [OP_W-1:0] OP_NAND  = 4'd5;
    localparam logic [OP_W-1:0] OP_XNOR  = 4'd6;
    localparam logic [OP_W-1:0] OP_PASSB = 4'd7;
    localparam logic [OP_W-1:0] OP_SHL   = 4'd8;
    localparam logic [OP_W-1:0] OP_SHR   = 4'd9;
    localparam logic [OP_W-1:0] OP_ROL   = 4'd10;
    localparam logic [OP_W-1:0] OP_ROR   = 4'd11;

    // Opcodes 12-15 are never legal; 8-11 only when the shifter is built.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
`ifdef LOGIC_SHIFT_EN
        return op <= OP_ROR;
`else
        return op <= OP_PASSB;
`endif
    endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Request/result bundle of the pipelined logic unit; master drives requests, slave is the unit.
interface logic_unit_pipe_if
    import logic_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_A;
    logic [WIDTH-1:0] op_B;
    logic [OP_W-1:0]  op_sel;
    logic             chain;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Func;
    logic             flag_zero;
    logic             flag_par;
    logic             flag_err;

    modport master (
        output in_valid, op_A, op_B, op_sel, chain, out_ready,
        input  in_ready, out_valid, Func, flag_zero, flag_par, flag_err
    );

    modport slave (
        input  in_valid, op_A, op_B, op_sel, chain, out_ready,
        output in_ready, out_valid, Func, flag_zero, flag_par, flag_err
    );
endinterface

// File: rtl/logic_unit_pipe_core.sv
// Combinational WIDTH-bit logic core: result and illegal-opcode flag for one operation.
// Build option: LOGIC_SHIFT_EN adds the one-position shift/rotate ops on A.
module logic_core
    import logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] res,
    output logic             err
);

    // Illegal opcodes fall into the default arm and yield zero.
    always_comb begin
        err = !is_legal_op(op);
        res = '0;
        case (op)
            OP_IOR:   res = a | b;
            OP_AND:   res = a & b;
            OP_XOR:   res = a ^ b;
            OP_COMP:  res = ~a;
            OP_NOR:   res = ~(a | b);
            OP_NAND:  res = ~(a & b);
            OP_XNOR:  res = ~(a ^ b);
            OP_PASSB: res = b;
`ifdef LOGIC_SHIFT_EN
            OP_SHL:   res = {a[WIDTH-2:0], 1'b0};
            OP_SHR:   res = {1'b0, a[WIDTH-1:1]};
            OP_ROL:   res = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:   res = {a[0], a[WIDTH-1:1]};
`endif
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit: one-deep output stage with valid/ready handshake,
// chain (feedback) register and zero/parity/error flags registered with the result.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_ACC = '0
) (
    input logic              clk,
    input logic              rst,
    logic_unit_pipe_if.slave bus
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] func_q, func_d;
    logic             zero_q, zero_d;
    logic             par_q, par_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] chain_q, chain_d;

    logic             accept;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] core_res;
    logic             core_err;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign operand_b    = bus.chain ? chain_q : bus.op_B;

    logic_core #(.WIDTH(WIDTH)) u_core (
        .a   (bus.op_A),
        .b   (operand_b),
        .op  (bus.op_sel),
        .res (core_res),
        .err (core_err)
    );

    // An accept overwrites the output stage even while it is being presented, so no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        func_d      = func_q;
        zero_d      = zero_q;
        par_d       = par_q;
        err_d       = err_q;
        chain_d     = chain_q;
        if (accept) begin
            out_valid_d = 1'b1;
            func_d      = core_res;
            zero_d      = (core_res == '0);
            par_d       = ^core_res;
            err_d       = core_err;
            chain_d     = core_res;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            func_q      <= '0;
            zero_q      <= 1'b0;
            par_q       <= 1'b0;
            err_q       <= 1'b0;
            chain_q     <= RESET_ACC;
        end else begin
            out_valid_q <= out_valid_d;
            func_q      <= func_d;
            zero_q      <= zero_d;
            par_q       <= par_d;
            err_q       <= err_d;
            chain_q     <= chain_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.Func      = func_q;
    assign bus.flag_zero = zero_q;
    assign bus.flag_par  = par_q;
    assign bus.flag_err  = err_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed testbench for logic_unit_pipe (WIDTH=8, RESET_ACC=0xA5); expectations
// for opcodes 8-11 follow whether LOGIC_SHIFT_EN is defined.
module tb_logic_unit_pipe;
    import logic_pkg::*;

    localparam int          WIDTH     = 8;
    localparam logic [7:0]  RESET_ACC = 8'hA5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

    logic_unit_pipe #(.WIDTH(WIDTH), .RESET_ACC(RESET_ACC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %02h expected %02h", tag, actual, expected);
        end
    endtask

    // Set up one request; the caller decides when the edge happens.
    task automatic applyStimulus(input logic valid, input logic [3:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic ch);
        bus.in_valid = valid;
        bus.op_sel   = op;
        bus.op_A     = a;
        bus.op_B     = b;
        bus.chain    = ch;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] basic_exp [4];
    logic [7:0] shift_exp [4];
    logic       shift_err;

    initial begin
        checks = 0;
        errors = 0;
        basic_exp = '{8'hDB, 8'h42, 8'h99, 8'h3C};
`ifdef LOGIC_SHIFT_EN
        shift_exp = '{8'h02, 8'h40, 8'h03, 8'hC0};
        shift_err = 1'b0;
`else
        shift_exp = '{8'h00, 8'h00, 8'h00, 8'h00};
        shift_err = 1'b1;
`endif

        rst           = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
        repeat (2) stepClock();
        checkOutput("reset out_valid", {7'd0, bus.out_valid}, 8'h00);
        checkOutput("reset Func", bus.Func, 8'h00);
        checkOutput("reset flag_zero", {7'd0, bus.flag_zero}, 8'h00);
        checkOutput("reset flag_par", {7'd0, bus.flag_par}, 8'h00);
        checkOutput("reset flag_err", {7'd0, bus.flag_err}, 8'h00);
        rst = 1'b0;
        #1;
        checkOutput("in_ready after reset", {7'd0, bus.in_ready}, 8'h01);

        // Back-to-back base ops with out_ready held high.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'(i), 8'hC3, 8'h5A, 1'b0);
            stepClock();
            checkOutput($sformatf("b2b op%0d Func", i), bus.Func, basic_exp[i]);
            checkOutput($sformatf("b2b op%0d valid", i), {7'd0, bus.out_valid}, 8'h01);
            checkOutput($sformatf("b2b op%0d par", i), {7'd0, bus.flag_par}, 8'h00);
            checkOutput($sformatf("b2b op%0d in_ready", i), {7'd0, bus.in_ready}, 8'h01);
        end

        // Stall: NOR result held while an AND waits.
        applyStimulus(1'b1, OP_NOR, 8'hF0, 8'h0F, 1'b0);
        stepClock();
        checkOutput("nor Func", bus.Func, 8'h00);
        checkOutput("nor zero", {7'd0, bus.flag_zero}, 8'h01);
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, OP_AND, 8'hF0, 8'h0F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput($sformatf("stall%0d Func", i), bus.Func, 8'h00);
            checkOutput($sformatf("stall%0d zero", i), {7'd0, bus.flag_zero}, 8'h01);
            checkOutput($sformatf("stall%0d valid", i), {7'd0, bus.out_valid}, 8'h01);
            checkOutput($sformatf("stall%0d in_ready", i), {7'd0, bus.in_ready}, 8'h00);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("unstall in_ready", {7'd0, bus.in_ready}, 8'h01);
        stepClock();
        checkOutput("after stall Func", bus.Func, 8'h00);
        checkOutput("after stall valid", {7'd0, bus.out_valid}, 8'h01);
        applyStimulus(1'b0, OP_AND, 8'h00, 8'h00, 1'b0);
        stepClock();
        checkOutput("drain valid", {7'd0, bus.out_valid}, 8'h00);
        checkOutput("drain Func held", bus.Func, 8'h00);

        // Odd parity case.
        applyStimulus(1'b1, OP_IOR, 8'h01, 8'h06, 1'b0);
        stepClock();
        checkOutput("ior Func", bus.Func, 8'h07);
        checkOutput("ior par", {7'd0, bus.flag_par}, 8'h01);
        checkOutput("ior zero", {7'd0, bus.flag_zero}, 8'h00);

        // Chain: passB 0x81 then XOR of 0xFF with the chained value.
        applyStimulus(1'b1, OP_PASSB, 8'h00, 8'h81, 1'b0);
        stepClock();
        checkOutput("passB Func", bus.Func, 8'h81);
        applyStimulus(1'b1, OP_XOR, 8'hFF, 8'h00, 1'b1);
        stepClock();
        checkOutput("chain xor Func", bus.Func, 8'h7E);
        checkOutput("chain xor par", {7'd0, bus.flag_par}, 8'h00);

        // Illegal opcode clears result and chain register.
        applyStimulus(1'b1, 4'd13, 8'hAA, 8'h55, 1'b0);
        stepClock();
        checkOutput("illegal Func", bus.Func, 8'h00);
        checkOutput("illegal err", {7'd0, bus.flag_err}, 8'h01);
        checkOutput("illegal zero", {7'd0, bus.flag_zero}, 8'h01);
        checkOutput("illegal par", {7'd0, bus.flag_par}, 8'h00);
        applyStimulus(1'b1, OP_PASSB, 8'h00, 8'hFF, 1'b1);
        stepClock();
        checkOutput("chain after illegal Func", bus.Func, 8'h00);
        checkOutput("chain after illegal err", {7'd0, bus.flag_err}, 8'h00);

        // Shift/rotate group.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'(8 + i), 8'h81, 8'h00, 1'b0);
            stepClock();
            checkOutput($sformatf("shift op%0d Func", 8 + i), bus.Func, shift_exp[i]);
            checkOutput($sformatf("shift op%0d err", 8 + i), {7'd0, bus.flag_err}, {7'd0, shift_err});
        end
        applyStimulus(1'b0, OP_IOR, 8'h00, 8'h00, 1'b0);
        stepClock();

        // Reset while a result is stalled.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, OP_PASSB, 8'h00, 8'h3C, 1'b0);
        stepClock();
        checkOutput("pre-reset Func", bus.Func, 8'h3C);
        checkOutput("pre-reset valid", {7'd0, bus.out_valid}, 8'h01);
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
        applyStimulus(1'b0, OP_PASSB, 8'h00, 8'h00, 1'b0);
        checkOutput("mid-stall reset valid", {7'd0, bus.out_valid}, 8'h00);
        checkOutput("mid-stall reset Func", bus.Func, 8'h00);
        checkOutput("mid-stall reset zero", {7'd0, bus.flag_zero}, 8'h00);
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, OP_PASSB, 8'h00, 8'h11, 1'b1);
        stepClock();
        checkOutput("chain RESET_ACC Func", bus.Func, RESET_ACC);
        checkOutput("chain RESET_ACC par", {7'd0, bus.flag_par}, 8'h00);
        applyStimulus(1'b0, OP_IOR, 8'h00, 8'h00, 1'b0);
        stepClock();
        checkOutput("final valid", {7'd0, bus.out_valid}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
